xleds_pwm: RTL and testbench
============================

// Module: xleds_pwm
// PURPOSE
//  Parametrised LED bank driver; successor to the 8-bit masked-latch LED block.
//  Holds per-channel on/off value and per-channel mode (static/blink/dim/blink+dim),
//  generates shared PWM and blink timebases, drives registered LED pins.
//  Sits between the calculator control logic and the board LEDs.
// PARAMETERS
//  N_LEDS      8   number of LED channels
//  PWM_BITS    4   PWM counter width; period = 2**PWM_BITS ticks
//  PRESCALE    1024 clk cycles per PWM tick (>=1)
//  BLINK_WRAPS 32  PWM wraps per blink half-period (>=1)
// PORTS
//  clk        in  1         system clock, all logic on posedge
//  reset      in  1         synchronous, active-high
//  led_input  in  N_LEDS    value bits to write
//  leds_sel   in  N_LEDS    per-channel write mask (1 = update channel)
//  mode_wr    in  1         1 = also write mode_in to selected channels
//  mode_in    in  2         00 static, 01 blink, 10 dim, 11 blink+dim
//  duty       in  PWM_BITS  global brightness for dim modes
//  leds       out N_LEDS    registered LED drive
// BEHAVIOUR
//  - Reset (sync, high): val=0, mode=00 all channels, prescaler=0, pwm_cnt=0,
//    wrap_cnt=0, blink_ph=0, duty_r=0, leds=0. Reset wins over every other input.
//  - Value write: each edge, val[i]<=led_input[i] where leds_sel[i]=1; else hold.
//  - Mode write: when mode_wr=1, mode[i]<=mode_in where leds_sel[i]=1.
//    Value and mode writes in same cycle both apply. leds_sel=0 -> no change.
//  - Timebase: prescaler counts 0..PRESCALE-1, tick on terminal count, wraps to 0.
//    pwm_cnt increments on tick, wraps 2**PWM_BITS-1 -> 0 (= pwm wrap).
//    wrap_cnt counts pwm wraps 0..BLINK_WRAPS-1; on terminal: blink_ph toggles.
//  - duty_r <= duty only on pwm wrap edge (and at reset to 0): glitch-free
//    brightness change; mid-period duty changes take effect next period.
//  - pwm_on = (pwm_cnt < duty_r). duty_r=0 -> never on.
//  - Per channel next leds[i]:
//      00: val[i]   01: val[i]&blink_ph   10: val[i]&pwm_on
//      11: val[i]&blink_ph&pwm_on
//  - Latency: write at edge k -> leds reflects at edge k+1 (one register stage).
//  - leds is the only output; no combinational path input->output.
//  - Timebase free-runs; writes never reset counters or blink phase.
// CONFIGURATION
//  XLEDS_FULL_ON_EN defined: duty_r all-ones forces pwm_on=1 (100% brightness).
//  Not defined: max brightness is (2**PWM_BITS-1)/2**PWM_BITS, pwm_on strictly
//  per compare rule above. All other behaviour identical.
// TESTING (N_LEDS=8, PWM_BITS=4, PRESCALE=2, BLINK_WRAPS=2; PWM period 32 clk,
//  blink half-period 64 clk)
//  1. reset; led_input=8'hA5, leds_sel=8'hFF one cycle -> leds=8'hA5 at next edge.
//  2. then led_input=8'h00, leds_sel=8'h0F -> leds=8'hA0; leds_sel=0 -> holds A0.
//  3. mode_wr=1,mode_in=01,leds_sel=8'h20 -> leds[5] low 64 clk, high 64 clk,
//     repeating; other bits static.
//  4. mode 10 on ch7, duty=4 -> leds[7] high exactly 8 of every 32 clk; duty=0
//     -> stays low; duty change mid-period applies only after next wrap.
//  5. reset asserted mid-blink -> leds=0 next edge, mode/val cleared, counters
//     restart from 0.
//  6. duty=4'hF, mode 10: with XLEDS_FULL_ON_EN leds high continuously;
//     without it low 2 of every 32 clk.

Source files
------------

// File: rtl/xleds_pwm.sv
`default_nettype none
// ============================================================================
// Module      : xleds_pwm
// Description : Parametrised LED bank driver. Each channel holds an on/off
//               value and a 2-bit mode (static / blink / dim / blink+dim).
//               A shared prescaler -> PWM counter -> blink divider timebase
//               gates the channel values onto registered LED pins.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in  1         system clock, all logic on posedge
//   reset      in  1         synchronous, active-high
//   led_input  in  N_LEDS    value bits to write
//   leds_sel   in  N_LEDS    per-channel write mask (1 = update channel)
//   mode_wr    in  1         1 = also write mode_in to selected channels
//   mode_in    in  2         00 static, 01 blink, 10 dim, 11 blink+dim
//   duty       in  PWM_BITS  global brightness for dim modes
//   leds       out N_LEDS    registered LED drive
// Configuration macro
//   XLEDS_FULL_ON_EN : when defined, an all-ones latched duty forces the PWM
//                      output permanently on (100% brightness).
// ============================================================================
module xleds_pwm #(
    parameter int N_LEDS      = 8,
    parameter int PWM_BITS    = 4,
    parameter int PRESCALE    = 1024,
    parameter int BLINK_WRAPS = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_LEDS-1:0]   led_input,
    input  logic [N_LEDS-1:0]   leds_sel,
    input  logic                mode_wr,
    input  logic [1:0]          mode_in,
    input  logic [PWM_BITS-1:0] duty,
    output logic [N_LEDS-1:0]   leds
);

    // Counter widths never drop below one bit so PRESCALE=1 / BLINK_WRAPS=1 work.
    localparam int c_PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int c_WR_W = (BLINK_WRAPS > 1) ? $clog2(BLINK_WRAPS) : 1;
    localparam logic [c_PS_W-1:0] c_PS_LAST = c_PS_W'(PRESCALE - 1);
    localparam logic [c_WR_W-1:0] c_WR_LAST = c_WR_W'(BLINK_WRAPS - 1);

    logic [c_PS_W-1:0]          r_presc_q,    w_presc_d;
    logic [PWM_BITS-1:0]        r_pwm_cnt_q,  w_pwm_cnt_d;
    logic [c_WR_W-1:0]          r_wrap_cnt_q, w_wrap_cnt_d;
    logic                       r_blink_ph_q, w_blink_ph_d;
    logic [PWM_BITS-1:0]        r_duty_q,     w_duty_d;
    logic [N_LEDS-1:0]          r_val_q,      w_val_d;
    logic [N_LEDS-1:0][1:0]     r_mode_q,     w_mode_d;
    logic [N_LEDS-1:0]          r_leds_q,     w_leds_d;

    logic w_tick;
    logic w_pwm_wrap;
    logic w_wrap_last;
    logic w_pwm_on;

    // ------------------------------------------------------------------
    // Shared timebase
    // ------------------------------------------------------------------
    always_comb begin
        w_tick       = (r_presc_q == c_PS_LAST);
        w_presc_d    = w_tick ? '0 : r_presc_q + 1'b1;
        w_pwm_wrap   = w_tick && (r_pwm_cnt_q == '1);
        // Natural binary overflow provides the 2**PWM_BITS-1 -> 0 wrap.
        w_pwm_cnt_d  = w_tick ? r_pwm_cnt_q + 1'b1 : r_pwm_cnt_q;
        w_wrap_last  = (r_wrap_cnt_q == c_WR_LAST);
        w_wrap_cnt_d = r_wrap_cnt_q;
        if (w_pwm_wrap) begin
            w_wrap_cnt_d = w_wrap_last ? '0 : r_wrap_cnt_q + 1'b1;
        end
        w_blink_ph_d = r_blink_ph_q ^ (w_pwm_wrap && w_wrap_last);
        // Duty is only sampled at a period boundary so a change never
        // produces a truncated or stretched pulse mid-period.
        w_duty_d     = w_pwm_wrap ? duty : r_duty_q;
    end

`ifdef XLEDS_FULL_ON_EN
    assign w_pwm_on = (r_pwm_cnt_q < r_duty_q) || (r_duty_q == '1);
`else
    assign w_pwm_on = (r_pwm_cnt_q < r_duty_q);
`endif

    // ------------------------------------------------------------------
    // Channel state and LED gating
    // ------------------------------------------------------------------
    always_comb begin
        w_val_d  = r_val_q;
        w_mode_d = r_mode_q;
        w_leds_d = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            if (leds_sel[i]) begin
                w_val_d[i] = led_input[i];
                if (mode_wr) begin
                    w_mode_d[i] = mode_in;
                end
            end
            // mode bit 0 enables blink gating, bit 1 enables PWM gating.
            w_leds_d[i] = r_val_q[i]
                        & (~r_mode_q[i][0] | r_blink_ph_q)
                        & (~r_mode_q[i][1] | w_pwm_on);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc_q    <= '0;
            r_pwm_cnt_q  <= '0;
            r_wrap_cnt_q <= '0;
            r_blink_ph_q <= 1'b0;
            r_duty_q     <= '0;
            r_val_q      <= '0;
            r_mode_q     <= '0;
            r_leds_q     <= '0;
        end else begin
            r_presc_q    <= w_presc_d;
            r_pwm_cnt_q  <= w_pwm_cnt_d;
            r_wrap_cnt_q <= w_wrap_cnt_d;
            r_blink_ph_q <= w_blink_ph_d;
            r_duty_q     <= w_duty_d;
            r_val_q      <= w_val_d;
            r_mode_q     <= w_mode_d;
            r_leds_q     <= w_leds_d;
        end
    end

    assign leds = r_leds_q;

endmodule
`default_nettype wire

// File: tb/tb_xleds_pwm.sv
`default_nettype none
// ============================================================================
// Module      : tb_xleds_pwm
// Description : Self-checking bench for xleds_pwm (N_LEDS=8, PWM_BITS=4,
//               PRESCALE=2, BLINK_WRAPS=2). A cycle-level reference model
//               derives the timebase arithmetically from the number of clock
//               edges since reset and predicts leds after every edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xleds_pwm;

    localparam int c_N   = 8;
    localparam int c_PB  = 4;
    localparam int c_PS  = 2;
    localparam int c_BW  = 2;
    localparam int c_PER = c_PS * (1 << c_PB);   // clk per PWM period

    logic            clk;
    logic            reset;
    logic [c_N-1:0]  led_input;
    logic [c_N-1:0]  leds_sel;
    logic            mode_wr;
    logic [1:0]      mode_in;
    logic [c_PB-1:0] duty;
    logic [c_N-1:0]  leds;

    xleds_pwm #(
        .N_LEDS     (c_N),
        .PWM_BITS   (c_PB),
        .PRESCALE   (c_PS),
        .BLINK_WRAPS(c_BW)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .led_input(led_input),
        .leds_sel (leds_sel),
        .mode_wr  (mode_wr),
        .mode_in  (mode_in),
        .duty     (duty),
        .leds     (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // ---------------- reference model ----------------
    logic [c_N-1:0] m_val;
    logic [1:0]     m_mode [c_N];
    int             m_n;        // clock edges since reset
    int             m_duty_r;

    function automatic logic [c_N-1:0] model_leds();
        logic [c_N-1:0] r;
        int  pwm_cnt;
        bit  on;
        bit  ph;
        pwm_cnt = (m_n / c_PS) % (1 << c_PB);
        on      = (pwm_cnt < m_duty_r);
`ifdef XLEDS_FULL_ON_EN
        if (m_duty_r == (1 << c_PB) - 1) on = 1'b1;
`endif
        ph = ((m_n / (c_PER * c_BW)) % 2) == 1;
        for (int i = 0; i < c_N; i++) begin
            case (m_mode[i])
                2'b00:   r[i] = m_val[i];
                2'b01:   r[i] = m_val[i] & ph;
                2'b10:   r[i] = m_val[i] & on;
                default: r[i] = m_val[i] & ph & on;
            endcase
        end
        return r;
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_val    = '0;
            for (int i = 0; i < c_N; i++) m_mode[i] = 2'b00;
            m_n      = 0;
            m_duty_r = 0;
        end else begin
            if ((m_n + 1) % c_PER == 0) m_duty_r = int'(duty);
            for (int i = 0; i < c_N; i++) begin
                if (leds_sel[i]) begin
                    m_val[i] = led_input[i];
                    if (mode_wr) m_mode[i] = mode_in;
                end
            end
            m_n++;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // One clock cycle: drive on negedge, predict, clock, compare just after.
    task automatic step(input logic [c_N-1:0] inp, input logic [c_N-1:0] sel,
                        input logic mw, input logic [1:0] mi,
                        input logic [c_PB-1:0] d, input logic rst);
        logic [c_N-1:0] exp;
        @(negedge clk);
        led_input = inp; leds_sel = sel; mode_wr = mw; mode_in = mi;
        duty = d; reset = rst;
        exp = rst ? '0 : model_leds();
        @(posedge clk);
        model_edge();
        #1;
        check("model_leds", int'(leds), int'(exp));
    endtask

    logic [c_PB-1:0] cur_duty;

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0, '0, 1'b0, 2'b00, cur_duty, 1'b0);
    endtask

    task automatic count_bit(input int bitn, input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            idle(1);
            cnt += int'(leds[bitn]);
        end
    endtask

    typedef struct {
        logic [c_N-1:0] inp;
        logic [c_N-1:0] sel;
        logic           mw;
        logic [1:0]     mi;
        logic [c_N-1:0] exp;
    } vec_t;

    vec_t tbl [5];
    int   cnt;
    bit   seen;

    initial begin
        tbl[0] = '{8'hA5, 8'hFF, 1'b0, 2'b00, 8'hA5};
        tbl[1] = '{8'h00, 8'h0F, 1'b0, 2'b00, 8'hA0};
        tbl[2] = '{8'hFF, 8'h00, 1'b1, 2'b11, 8'hA0};
        tbl[3] = '{8'h5A, 8'hF0, 1'b0, 2'b00, 8'h50};
        tbl[4] = '{8'hFF, 8'h03, 1'b1, 2'b00, 8'h53};

        cur_duty = '0;
        led_input = '0; leds_sel = '0; mode_wr = 1'b0; mode_in = 2'b00;
        duty = '0; reset = 1'b1;

        // Reset state
        step('0, '0, 1'b0, 2'b00, '0, 1'b1);
        step('0, '0, 1'b0, 2'b00, '0, 1'b1);
        check("reset_leds", int'(leds), 0);

        // Value/mask writes: write one cycle, leds reflect one edge later.
        foreach (tbl[v]) begin
            step(tbl[v].inp, tbl[v].sel, tbl[v].mw, tbl[v].mi, cur_duty, 1'b0);
            idle(1);
            check($sformatf("tbl_%0d", v), int'(leds), int'(tbl[v].exp));
        end

        // Blink on channel 5: square wave of 64 clk low / 64 high.
        step('0, '0, 1'b0, 2'b00, '0, 1'b1);
        step(8'hFF, 8'hFF, 1'b0, 2'b00, cur_duty, 1'b0);
        step(8'hFF, 8'h20, 1'b1, 2'b01, cur_duty, 1'b0);
        idle(3);
        count_bit(5, 128, cnt);
        check("blink_hi_of_128", cnt, 64);
        count_bit(4, 128, cnt);
        check("static_ch4_hi_of_128", cnt, 128);

        // Reset mid-blink: wait until ch5 is high, then reset.
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            idle(1);
            seen = leds[5];
        end
        check("blink_reached_high", int'(seen), 1);
        step('0, '0, 1'b0, 2'b00, cur_duty, 1'b1);
        check("reset_mid_blink", int'(leds), 0);
        idle(1);
        check("val_cleared", int'(leds), 0);
        // Mode cleared: ch5 now static, so all-ones shows immediately.
        step(8'hFF, 8'hFF, 1'b0, 2'b00, cur_duty, 1'b0);
        idle(1);
        check("mode_cleared", int'(leds), 8'hFF);

        // Dim on channel 7.
        cur_duty = 4'd4;
        step(8'hFF, 8'h80, 1'b1, 2'b10, cur_duty, 1'b0);
        idle(40);
        count_bit(7, 32, cnt);
        check("dim4_hi_of_32", cnt, 8);
        // Mid-period change to 0: bit 7 still pulses in current period.
        cur_duty = 4'd0;
        idle(40);
        count_bit(7, 32, cnt);
        check("dim0_hi_of_32", cnt, 0);
        cur_duty = 4'hF;
        idle(40);
        count_bit(7, 32, cnt);
`ifdef XLEDS_FULL_ON_EN
        check("dimF_hi_of_32", cnt, 32);
`else
        check("dimF_hi_of_32", cnt, 30);
`endif

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            logic [c_N-1:0] s;
            s = ($urandom_range(0, 3) == 0) ? c_N'($urandom) : '0;
            if ($urandom_range(0, 19) == 0) cur_duty = c_PB'($urandom);
            step(c_N'($urandom), s, 1'($urandom), 2'($urandom), cur_duty,
                 $urandom_range(0, 299) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
